// File: rtl/dft_scan_responder.sv
// dft_scan_responder
// Per-chain responder for the wrapper DFT handshake. On a request it acks,
// rotates the attached scan chain exactly once (scan_out looped back to
// scan_in) so the DUT state is preserved, and streams the captured bits out
// as p_word_width-bit words, one strobe per word. It then raises commit and
// waits for the initiator's commit acknowledge.
//
// Ports
//   clk                 clock, rising edge
//   reset               synchronous, active-low
//   dft_val_op          request from initiator (held until ack)
//   dft_op_ack          1-cycle request acknowledge
//   dft_op_commit       scan complete, held until dft_commit_ack sampled
//   dft_commit_ack      commit acknowledge from initiator
//   dft_output_strobe   1-cycle pulse, dft_output_data valid
//   dft_output_data     captured scan word (first chain bit out in bit 0)
//   scan_en             shift enable to the DUT scan muxes
//   scan_in             serial data into the chain head
//   scan_out            serial data from the chain tail
//   busy                high outside IDLE
//
// state     | meaning
// ----------+------------------------------------------------------------
// st_idle   | waiting for dft_val_op; bit counter and word register cleared
// st_ack    | dft_op_ack high for one cycle
// st_shift  | chain rotating, one bit captured per cycle
// st_flush  | one cycle with scan_en low; final word strobes here
// st_commit | dft_op_commit high until dft_commit_ack is sampled

module dft_scan_responder #(
  parameter int p_chain_len  = 256,
  parameter int p_word_width = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dft_val_op,
  output logic                    dft_op_ack,
  output logic                    dft_op_commit,
  input  logic                    dft_commit_ack,
  output logic                    dft_output_strobe,
  output logic [p_word_width-1:0] dft_output_data,
  output logic                    scan_en,
  output logic                    scan_in,
  input  logic                    scan_out,
  output logic                    busy
);

  localparam int c_cnt_w = $clog2(p_chain_len + 1);
  localparam int c_idx_w = (p_word_width > 1) ? $clog2(p_word_width) : 1;

  typedef enum logic [2:0] {
    st_idle,
    st_ack,
    st_shift,
    st_flush,
    st_commit
  } state_t;

  state_t                  state;
  logic [c_cnt_w-1:0]      bit_cnt;
  logic [c_idx_w-1:0]      word_idx;
  logic [p_word_width-1:0] word_q;

  logic last_bit;
  logic word_full;

  assign last_bit  = (bit_cnt == c_cnt_w'(p_chain_len - 1));
  assign word_full = (word_idx == c_idx_w'(p_word_width - 1));

  // Loopback is combinational so the chain rotates without a pipeline bubble;
  // gated by scan_en so scan_in is 0 whenever the chain is not shifting.
  assign scan_in = scan_en & scan_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= st_idle;
      bit_cnt           <= '0;
      word_idx          <= '0;
      word_q            <= '0;
      dft_op_ack        <= 1'b0;
      dft_op_commit     <= 1'b0;
      dft_output_strobe <= 1'b0;
      dft_output_data   <= '0;
      scan_en           <= 1'b0;
      busy              <= 1'b0;
    end else begin
      dft_op_ack        <= 1'b0;
      dft_output_strobe <= 1'b0;

      case (state)
        st_idle: begin
          bit_cnt  <= '0;
          word_idx <= '0;
          word_q   <= '0;
          if (dft_val_op) begin
            state      <= st_ack;
            dft_op_ack <= 1'b1;
            busy       <= 1'b1;
          end
        end

        st_ack: begin
          state   <= st_shift;
          scan_en <= 1'b1;
        end

        st_shift: begin
          // The completing bit is merged straight into the output register so
          // the word strobes the cycle after its last capture.
          if (word_full || last_bit) begin
            dft_output_data   <= word_q | (p_word_width'(scan_out) << word_idx);
            dft_output_strobe <= 1'b1;
            word_q            <= '0;
            word_idx          <= '0;
          end else begin
            word_q[word_idx] <= scan_out;
            word_idx         <= word_idx + c_idx_w'(1);
          end
          bit_cnt <= bit_cnt + c_cnt_w'(1);
          if (last_bit) begin
            state   <= st_flush;
            scan_en <= 1'b0;
          end
        end

        st_flush: begin
          state         <= st_commit;
          dft_op_commit <= 1'b1;
        end

        st_commit: begin
          if (dft_commit_ack) begin
            state         <= st_idle;
            dft_op_commit <= 1'b0;
            busy          <= 1'b0;
          end
        end

        default: begin
          state         <= st_idle;
          scan_en       <= 1'b0;
          dft_op_commit <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dft_scan_responder.sv
// Directed bench for dft_scan_responder with three chain lengths (64, 40, 1),
// each instance attached to a behavioural scan chain model.
module tb_dft_scan_responder;

  localparam logic [63:0] c_v64 = 64'hDEADBEEF_01234567;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-bit chain instance
  logic        val64, ack64, com64, cack64, stb64, se64, si64, so64, busy64;
  logic [31:0] d64;
  logic [63:0] ch64;
  logic        load64;
  logic [63:0] pre64;

  // 40-bit chain instance
  logic        val40, ack40, com40, cack40, stb40, se40, si40, so40, busy40;
  logic [31:0] d40;
  logic [39:0] ch40;
  logic        load40;

  // 1-bit chain instance
  logic        val1, ack1, com1, cack1, stb1, se1, si1, so1, busy1;
  logic [31:0] d1;
  logic        ch1;
  logic        load1;

  int n_checks;
  int n_errors;

  dft_scan_responder #(.p_chain_len(64), .p_word_width(32)) u64 (
    .clk(clk), .reset(reset),
    .dft_val_op(val64), .dft_op_ack(ack64),
    .dft_op_commit(com64), .dft_commit_ack(cack64),
    .dft_output_strobe(stb64), .dft_output_data(d64),
    .scan_en(se64), .scan_in(si64), .scan_out(so64), .busy(busy64)
  );

  dft_scan_responder #(.p_chain_len(40), .p_word_width(32)) u40 (
    .clk(clk), .reset(reset),
    .dft_val_op(val40), .dft_op_ack(ack40),
    .dft_op_commit(com40), .dft_commit_ack(cack40),
    .dft_output_strobe(stb40), .dft_output_data(d40),
    .scan_en(se40), .scan_in(si40), .scan_out(so40), .busy(busy40)
  );

  dft_scan_responder #(.p_chain_len(1), .p_word_width(32)) u1 (
    .clk(clk), .reset(reset),
    .dft_val_op(val1), .dft_op_ack(ack1),
    .dft_op_commit(com1), .dft_commit_ack(cack1),
    .dft_output_strobe(stb1), .dft_output_data(d1),
    .scan_en(se1), .scan_in(si1), .scan_out(so1), .busy(busy1)
  );

  // Scan chain models: head takes scan_in, tail (bit 0) drives scan_out.
  always @(posedge clk) begin
    if (load64)    ch64 <= pre64;
    else if (se64) ch64 <= {si64, ch64[63:1]};
    if (load40)    ch40 <= '1;
    else if (se40) ch40 <= {si40, ch40[39:1]};
    if (load1)     ch1  <= 1'b1;
    else if (se1)  ch1  <= si1;
  end
  assign so64 = ch64[0];
  assign so40 = ch40[0];
  assign so1  = ch1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller is at the negedge of cycle 0; raises the request and checks
  // cycles 1..67. Returns at the negedge of cycle 67 (first commit cycle).
  task automatic op64(input logic [63:0] v, input bit hold);
    val64 = 1'b1;
    for (int c = 1; c <= 67; c++) begin
      @(negedge clk);
      chk("ack64",     64'(ack64),  64'(c == 1));
      chk("scan_en64", 64'(se64),   64'(c >= 2 && c <= 65));
      chk("busy64",    64'(busy64), 64'(1));
      chk("strobe64",  64'(stb64),  64'(c == 34 || c == 66));
      chk("commit64",  64'(com64),  64'(c == 67));
      if (c == 34) chk("word0_64", 64'(d64), 64'(v[31:0]));
      if (c == 66) chk("word1_64", 64'(d64), 64'(v[63:32]));
      if (c == 1 && !hold) val64 = 1'b0;
      if (c == 2) cack64 = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset  = 1'b0;
    val64 = 1'b0; cack64 = 1'b0; load64 = 1'b0; pre64 = c_v64;
    val40 = 1'b0; cack40 = 1'b0; load40 = 1'b0;
    val1  = 1'b0; cack1  = 1'b0; load1  = 1'b0;

    // Reset state and chain preload
    @(negedge clk);
    load64 = 1'b1; load40 = 1'b1; load1 = 1'b1;
    @(negedge clk);
    load64 = 1'b0; load40 = 1'b0; load1 = 1'b0;
    @(negedge clk);
    chk("rst_ack",    64'({ack64, ack40, ack1}),    64'(0));
    chk("rst_commit", 64'({com64, com40, com1}),    64'(0));
    chk("rst_strobe", 64'({stb64, stb40, stb1}),    64'(0));
    chk("rst_scan",   64'({se64, si64, se40, si40, se1, si1}), 64'(0));
    chk("rst_busy",   64'({busy64, busy40, busy1}), 64'(0));
    chk("rst_data",   {d64, d40 | d1},              64'(0));
    reset = 1'b1;

    // Test 1: 64-bit chain, pulsed request
    @(negedge clk);
    op64(c_v64, 1'b0);
    cack64 = 1'b1;
    @(negedge clk);
    chk("t1_commit_low", 64'(com64),  64'(0));
    chk("t1_busy_low",   64'(busy64), 64'(0));
    chk("t1_chain",      ch64,        c_v64);
    cack64 = 1'b0;

    // Test 2: 40-bit chain of ones, partial final word
    @(negedge clk);
    val40 = 1'b1;
    for (int c = 1; c <= 43; c++) begin
      @(negedge clk);
      chk("ack40",    64'(ack40), 64'(c == 1));
      chk("strobe40", 64'(stb40), 64'(c == 34 || c == 42));
      chk("commit40", 64'(com40), 64'(c == 43));
      if (c == 34) chk("word0_40", 64'(d40), 64'h0000_0000_FFFF_FFFF);
      if (c == 42) chk("word1_40", 64'(d40), 64'h0000_0000_0000_00FF);
      if (c == 1) val40 = 1'b0;
    end
    cack40 = 1'b1;
    @(negedge clk);
    chk("t2_commit_low", 64'(com40), 64'(0));
    chk("t2_chain",      64'(ch40),  64'h00_FFFF_FFFF_FF);
    cack40 = 1'b0;

    // Test 3: single-bit chain
    @(negedge clk);
    val1 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("ack1",     64'(ack1), 64'(c == 1));
      chk("scan_en1", 64'(se1),  64'(c == 2));
      chk("strobe1",  64'(stb1), 64'(c == 3));
      chk("commit1",  64'(com1), 64'(c == 4));
      if (c == 2) chk("scan_in1", 64'(si1), 64'(1));
      if (c == 3) chk("word0_1",  64'(d1),  64'(1));
      if (c == 1) val1 = 1'b0;
    end
    cack1 = 1'b1;
    @(negedge clk);
    chk("t3_commit_low", 64'(com1), 64'(0));
    cack1 = 1'b0;

    // Test 4: commit ack delayed 5 cycles, held 3 more; immediate re-request
    @(negedge clk);
    op64(c_v64, 1'b0);
    for (int c = 68; c <= 72; c++) begin
      @(negedge clk);
      chk("t4_commit_wait", 64'(com64), 64'(1));
    end
    cack64 = 1'b1;
    @(negedge clk);
    chk("t4_commit_low", 64'(com64),  64'(0));
    chk("t4_busy_low",   64'(busy64), 64'(0));

    // Test 5: request held high through the whole operation (op64 drops
    // the lingering commit ack two cycles in)
    op64(c_v64, 1'b1);
    cack64 = 1'b1;
    @(negedge clk);
    chk("t5_commit_low", 64'(com64),  64'(0));
    chk("t5_no_ack",     64'(ack64),  64'(0));
    chk("t5_busy_low",   64'(busy64), 64'(0));
    cack64 = 1'b0;
    op64(c_v64, 1'b0);
    cack64 = 1'b1;
    @(negedge clk);
    chk("t5_chain", ch64, c_v64);
    cack64 = 1'b0;

    // Test 6: reset at shift index 10, then a clean operation
    @(negedge clk);
    val64 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) val64 = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("t6_outs", 64'({ack64, com64, stb64, se64, si64, busy64}), 64'(0));
    chk("t6_data", 64'(d64), 64'(0));
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t6_quiet", 64'({stb64, com64, busy64}), 64'(0));
    end
    op64((c_v64 >> 11) | (c_v64 << 53), 1'b0);
    cack64 = 1'b1;
    @(negedge clk);
    chk("t6_commit_low", 64'(com64), 64'(0));
    cack64 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dft_scan_responder.md
# dft_scan_responder

Per-chain responder for the wrapper's DFT handshake (`dft_val_op`/`dft_op_ack`, `dft_op_commit`/`dft_commit_ack`, `dft_output_strobe`). One instance sits between the wrapper control unit's bit `i` of each DFT bus and one DUT scan chain. On a request it acknowledges, circularly shifts the chain once around so the DUT state is preserved, and streams the captured bits out as `p_word_width`-bit words with a strobe per word. It then commits and waits for the commit acknowledge.

## Interface
- `p_chain_len`, default 256: scan chain length in bits, minimum 1.
- `p_word_width`, default 32: output word width in bits.
- `clk` in 1: clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled low at a rising `clk` edge resets the block.
- `dft_val_op` in 1: request from the initiator, held until `dft_op_ack` is seen.
- `dft_op_ack` out 1: request acknowledge, a 1-cycle pulse.
- `dft_op_commit` out 1: scan complete, held until `dft_commit_ack` is sampled.
- `dft_commit_ack` in 1: commit acknowledge from the initiator.
- `dft_output_strobe` out 1: `dft_output_data` is valid this cycle (1-cycle pulse per word).
- `dft_output_data` out `p_word_width`: captured scan word.
- `scan_en` out 1: chain shift enable to the DUT scan muxes.
- `scan_in` out 1: serial data into the chain head.
- `scan_out` in 1: serial data from the chain tail.
- `busy` out 1: high in every state except IDLE.

## Operation
- Derived constants:
  - `N_WORDS = ceil(p_chain_len/p_word_width)`.
  - Bit counter width `$clog2(p_chain_len+1)`.
  - Word-bit index width `$clog2(p_word_width)`.
- States: IDLE, ACK, SHIFT, FLUSH, COMMIT.
  - IDLE: if `dft_val_op`=1, go to ACK. Otherwise stay. Clear the bit counter and the word register.
  - ACK: `dft_op_ack`=1. Always go to SHIFT, even if `dft_val_op` has already dropped.
  - SHIFT: `scan_en`=1 and `scan_in`=`scan_out` (combinational loopback).
    - Each cycle, capture `scan_out` into word bit `(k mod p_word_width)`, where `k` is the shift index 0..`p_chain_len`-1. The first bit out of the chain lands in bit 0.
    - After the capture of `k=p_chain_len-1`, go to FLUSH.
  - FLUSH: one cycle, `scan_en`=0. Go to COMMIT.
  - COMMIT: `dft_op_commit`=1. If `dft_commit_ack`=1, go to IDLE; otherwise stay.
- Word emission:
  - When the capture edge stores bit `p_word_width-1` of a word, or the last chain bit, the next cycle drives `dft_output_strobe`=1 with the completed word on `dft_output_data`.
  - The word register is then cleared for the next word.
- Partial final word (`p_chain_len` not a multiple of `p_word_width`): unused upper bits are 0.
- Ignored inputs:
  - `dft_val_op` is ignored outside IDLE.
  - `dft_commit_ack` is ignored outside COMMIT.
  - `dft_commit_ack` still high on return to IDLE has no effect.
- Reset values:
  - All outputs 0 (`scan_in` 0), state IDLE, counters 0.
  - Reset mid-SHIFT abandons the operation. No strobe or commit follows, and the chain is left partially rotated. Re-running a full operation restores a rotation-consistent state only if the initiator has accounted for this; the block does not recover it.

## Timing
- Reference: cycle 0 is the cycle in which `dft_val_op`=1 is sampled in IDLE.
- Handshake and shift:
  - `dft_op_ack`=1 in cycle 1 only.
  - SHIFT occupies cycles 2..`p_chain_len`+1.
  - FLUSH is cycle `p_chain_len`+2.
  - `dft_op_commit` rises in cycle `p_chain_len`+3.
- Strobes:
  - Word w < `N_WORDS`-1 strobes in cycle 2+`p_word_width`·(w+1).
  - The final word strobes in cycle `p_chain_len`+2 (FLUSH).
  - The final strobe is therefore never coincident with `dft_op_commit`.
- Commit:
  - `dft_op_commit` is low in the cycle after `dft_commit_ack` is sampled in COMMIT.
  - Minimum commit width is 1 cycle, when the ack is already high on entry.
- Back-to-back: the earliest next request is sampled in the first IDLE cycle. Round trip is `p_chain_len`+4 cycles plus commit wait.
- `dft_output_data` holds its last value outside strobe cycles and is only meaningful with the strobe.

## Test plan
- `p_chain_len`=64, chain preloaded 0xDEADBEEF_01234567 (tail bit first = bit 0 of the low word), pulse request, ack held → `dft_op_ack` in cycle 1 only; strobes in cycles 34 and 66 with 0x01234567 then 0xDEADBEEF; commit in cycle 67; chain contents unchanged after the operation.
- `p_chain_len`=40, chain all ones → words 0xFFFFFFFF (cycle 34) and 0x000000FF (cycle 42); `dft_op_commit` in cycle 43.
- `p_chain_len`=1, `scan_out`=1 → single strobe 0x00000001 in cycle 3, commit in cycle 4.
- Commit ack delayed 5 cycles, then held high for 3 more → `dft_op_commit` high exactly until the ack is sampled, low the next cycle; a new `dft_val_op` sampled in the first IDLE cycle is acked the cycle after.
- `dft_val_op` held high through SHIFT and COMMIT → no second ack and no restart; the next ack is issued only after the return to IDLE.
- `reset` low for 1 cycle at shift index 10 → all outputs 0 the next cycle, no further strobes, `busy`=0; a subsequent request completes normally.
